ff_pipe_reg: RTL and testbench

FF_PIPE_REG -- requirements
Module: ff_pipe_reg

---
 rtl/ff_pkg.sv | 16 +
 rtl/ff_pipe_stage.sv | 35 +++
 rtl/ff_pipe_reg.sv | 105 ++++++++++
 tb/tb_ff_pipe_reg.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// Shared constants and types for the ff_pipe_reg register-slice pipeline.
package ff_pkg;

  localparam int FF_DEFAULT_WIDTH = 16;
  localparam int FF_MAX_DEPTH     = 16;

  // Occupancy counter wide enough for the deepest legal pipe (0..FF_MAX_DEPTH).
  localparam int FF_OCC_W = $clog2(FF_MAX_DEPTH + 1);
  typedef logic [FF_OCC_W-1:0] ff_occ_t;

  // Occupancy width actually exposed for a given depth.
  function automatic int ff_occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ff_pipe_stage.sv
// One pipeline slot: a valid bit plus a data word. Loads from its upstream
// neighbour when told to advance; flush and reset both empty the slot and
// park the data at the supplied reset value.
module ff_pipe_stage
  import ff_pkg::*;
#(
  parameter int WIDTH = FF_DEFAULT_WIDTH
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             adv,
  input  logic             flush,
  input  logic [WIDTH-1:0] reset_value,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // Slot state: flush beats advance; data only moves when real data arrives
  // so an empty advance keeps the old word and avoids needless toggling.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      v <= 1'b0;
      d <= reset_value;
    end else if (flush) begin
      v <= 1'b0;
      d <= reset_value;
    end else if (adv) begin
      v <= up_valid;
      if (up_valid) d <= up_data;
    end
  end

endmodule

// File: rtl/ff_pipe_reg.sv
// ff_pipe_reg: DEPTH-stage valid/ready register pipeline with bubble
// collapse, synchronous flush and asynchronous active-low reset.
// Optional feature: define FF_PIPE_OCC_EN to add the registered __occ
// occupancy count port.
module ff_pipe_reg
  import ff_pkg::*;
#(
  parameter int WIDTH = FF_DEFAULT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             __clk,
  input  logic             __arst_n,
  input  logic [WIDTH-1:0] __reset_value,
  input  logic             __flush,
  input  logic             __in_valid,
  output logic             __in_ready,
  input  logic [WIDTH-1:0] __in_data,
  output logic             __out_valid,
  input  logic             __out_ready,
  output logic [WIDTH-1:0] __out_data
`ifdef FF_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] __occ
`endif
);

  localparam int LAST = DEPTH - 1;

  if (DEPTH < 1 || DEPTH > FF_MAX_DEPTH) begin : g_bad_depth
    $error("ff_pipe_reg: DEPTH must be in 1..16");
  end

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0][WIDTH-1:0] d;

  // Advance chain, resolved from the output side back: a slot moves when it
  // is empty (bubble collapse) or when whatever sits in it is leaving.
  always_comb begin
    adv       = '0;
    adv[LAST] = !v[LAST] || __out_ready;
    for (int i = LAST - 1; i >= 0; i--) begin
      adv[i] = !v[i] || adv[i+1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    if (i == 0) begin : g_head
      assign up_v = __in_valid;
      assign up_d = __in_data;
    end else begin : g_body
      assign up_v = v[i-1];
      assign up_d = d[i-1];
    end

    ff_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .gclk        (__clk),
      .grst_n      (__arst_n),
      .adv         (adv[i]),
      .flush       (__flush),
      .reset_value (__reset_value),
      .up_valid    (up_v),
      .up_data     (up_d),
      .v           (v[i]),
      .d           (d[i])
    );
  end

  // Flush masks both handshakes so nothing counts as transferred that cycle.
  assign __in_ready  = adv[0] && !__flush;
  assign __out_valid = v[LAST] && !__flush;
  // While reset is held the output tracks the reset value live, even if it
  // moves after the reset edge.
  assign __out_data  = __arst_n ? d[LAST] : __reset_value;

`ifdef FF_PIPE_OCC_EN
  ff_occ_t occ_q;
  logic    in_xfer, out_xfer;

  assign in_xfer  = __in_valid && __in_ready;
  assign out_xfer = __out_valid && __out_ready;

  // Occupancy: +1 on accept, -1 on deliver, unchanged when both or neither.
  always_ff @(posedge __clk or negedge __arst_n) begin
    if (!__arst_n) begin
      occ_q <= '0;
    end else if (__flush) begin
      occ_q <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   occ_q <= occ_q + ff_occ_t'(1);
        2'b01:   occ_q <= occ_q - ff_occ_t'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign __occ = occ_q[$clog2(DEPTH+1)-1:0];
`else
  // No occupancy tracking in this build.
`endif

endmodule

// File: tb/tb_ff_pipe_reg.sv
// Scoreboard bench for ff_pipe_reg (DEPTH=3): accepted inputs are queued with
// their expected arrival cycle; a monitor pops on every output transfer.
module tb_ff_pipe_reg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             arst_n = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] reset_value = 16'hA5A5;
  logic [WIDTH-1:0] in_data = '0;
  logic [WIDTH-1:0] out_data;
`ifdef FF_PIPE_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occ;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit lat_chk = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
    bit               lat;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  ff_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .__clk         (clk),
    .__arst_n      (arst_n),
    .__reset_value (reset_value),
    .__flush       (flush),
    .__in_valid    (in_valid),
    .__in_ready    (in_ready),
    .__in_data     (in_data),
    .__out_valid   (out_valid),
    .__out_ready   (out_ready),
    .__out_data    (out_data)
`ifdef FF_PIPE_OCC_EN
    ,
    .__occ         (occ)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask

  task automatic chk_occ(input string n, input logic [31:0] exp);
`ifdef FF_PIPE_OCC_EN
    chk(n, 32'(occ), exp);
`else
    if (n.len() == 0 && exp == 0) $display("occ: %s", n);
`endif
  endtask

  // Record every accepted input with the cycle it must appear at the output.
  always @(negedge clk)
    if (arst_n && in_valid && in_ready)
      sb.push_back(exp_t'{in_data, cyc + DEPTH, lat_chk});

  // Compare every delivered word against the head of the scoreboard.
  always @(negedge clk)
    if (arst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out act=%0h exp=none", out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        if (e.lat) chk("latency", cyc, e.due);
      end
    end

  task automatic send(input logic [WIDTH-1:0] val);
    int n = 0;
    in_valid = 1'b1;
    in_data  = val;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout act=stalled exp=accept data=%0h", val);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string n);
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(n, sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 arst_n = 1'b0;
    #11;
    chk("rst_out_data", 32'(out_data), 32'h0000A5A5);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk_occ("rst_occ", 0);
    @(posedge clk); #1;
    arst_n = 1'b1;

    // Streaming: 1,2,3 back to back, each DEPTH cycles after acceptance
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    send(16'h0001);
    send(16'h0002);
    send(16'h0003);
    drain("drain_stream");
    lat_chk = 1'b0;

    // Stall: three fill the pipe, the fourth waits, then all drain in order
    out_ready = 1'b0;
    send(16'h0011);
    send(16'h0012);
    send(16'h0013);
    in_valid = 1'b1;
    in_data  = 16'h0014;
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_out_valid", 32'(out_valid), 1);
    chk("full_out_data", 32'(out_data), 32'h11);
    chk_occ("full_occ", 3);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_passthru_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("drain_stall");

    // Flush with a pending input: nothing accepted, pipe empties
    out_ready = 1'b0;
    send(16'h0021);
    send(16'h0022);
    in_valid = 1'b1;
    in_data  = 16'h00EE;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("post_flush_valid", 32'(out_valid), 0);
    chk("post_flush_data", 32'(out_data), 32'h0000A5A5);
    chk_occ("post_flush_occ", 0);

    // Reset value change outside reset/flush leaves stored data alone
    reset_value = 16'h1234;
    @(negedge clk);
    chk("rv_change_hold", 32'(out_data), 32'h0000A5A5);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'h0031);
    drain("drain_flush");

    // Bubble collapse: last stage full, middle empty, stage 0 full
    out_ready = 1'b0;
    send(16'h0041);
    repeat (2) @(posedge clk);
    #1;
    send(16'h0042);
    @(negedge clk);
    chk("collapse_in_ready", 32'(in_ready), 1);
    chk("collapse_out_data", 32'(out_data), 32'h41);
    chk_occ("collapse_occ", 2);
    @(posedge clk); #1;
    send(16'h0043);
    @(negedge clk);
    chk("collapse_full_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("drain_collapse");

    // Asynchronous reset mid-stream, then fresh traffic with DEPTH latency
    out_ready = 1'b0;
    send(16'h0051);
    send(16'h0052);
    send(16'h0053);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 1);
    @(posedge clk); #3;
    arst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_out_data", 32'(out_data), 32'h1234);
    chk_occ("arst_occ", 0);
    sb.delete();
    @(posedge clk); #2;
    arst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    send(16'h0061);
    send(16'h0062);
    drain("drain_after_rst");
    lat_chk = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
